// File: rtl/tetris_pkg.sv
// Playfield geometry, line-clear FSM encoding and row constants shared by
// gamelogic, board_store and the VGA renderer.
package tetris_pkg;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int XW   = 4;
    localparam int YW   = 5;

    localparam logic [COLS-1:0] FULL_ROW = {COLS{1'b1}};

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_SCAN = 2'd1,
        CLR_FILL = 2'd2,
        CLR_DONE = 2'd3
    } clr_state_e;

endpackage

// File: rtl/board_store.sv
// Playfield occupancy memory: collision read port, lock-write port, registered
// VGA read port and the full-row line-clear/compaction engine.
module board_store
    import tetris_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic [XW-1:0] board_rx,
    input  logic [YW-1:0] board_ry,
    output logic          board_rdata,
    input  logic          board_we,
    input  logic [XW-1:0] board_wx,
    input  logic [YW-1:0] board_wy,
    input  logic          board_wdata,
    input  logic [XW-1:0] vga_rx,
    input  logic [YW-1:0] vga_ry,
    output logic          vga_rdata,
    input  logic          clear_start,
    input  logic          clear_all,
    output logic          busy,
    output logic          clear_done,
    output logic [2:0]    lines_cleared,
    output logic          top_occupied
);

    localparam logic [XW-1:0]        COLS_X   = XW'(COLS);
    localparam logic [YW-1:0]        ROWS_Y   = YW'(ROWS);
    localparam logic signed [YW:0]   LAST_ROW = (YW+1)'(ROWS-1);
    localparam logic signed [YW:0]   ONE      = (YW+1)'(1);

    logic [COLS-1:0]     rows_q [ROWS];
    logic [COLS-1:0]     rows_d [ROWS];
    clr_state_e          state_q, state_d;
    logic signed [YW:0]  src_q, src_d;
    logic signed [YW:0]  dst_q, dst_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          lines_q, lines_d;
    logic                vga_q, vga_d;

    logic                board_in_range;
    logic                wr_in_range;
    logic                vga_in_range;
    logic [COLS-1:0]     src_row;
    logic                src_full;

    assign board_in_range = (board_rx < COLS_X) && (board_ry < ROWS_Y);
    assign wr_in_range    = (board_wx < COLS_X) && (board_wy < ROWS_Y);
    assign vga_in_range   = (vga_rx < COLS_X) && (vga_ry < ROWS_Y);

    // Out-of-range collision reads look like a wall so pieces stop at the edges.
    assign board_rdata   = board_in_range ? rows_q[board_ry][board_rx] : 1'b1;
    assign vga_rdata     = vga_q;
    assign busy          = (state_q != CLR_IDLE);
    assign clear_done    = (state_q == CLR_DONE);
    assign lines_cleared = lines_q;
    assign top_occupied  = |rows_q[0];

    assign src_row  = rows_q[src_q[YW-1:0]];
    assign src_full = (src_row == FULL_ROW);

    always_comb begin
        rows_d  = rows_q;
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        vga_d   = vga_in_range ? rows_q[vga_ry][vga_rx] : 1'b0;

        if (clear_all) begin
            for (int i = 0; i < ROWS; i++) begin
                rows_d[i] = '0;
            end
            state_d = CLR_IDLE;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (board_we && wr_in_range) begin
                        rows_d[board_wy][board_wx] = board_wdata;
                    end
                    if (clear_start) begin
                        state_d = CLR_SCAN;
                        src_d   = LAST_ROW;
                        dst_d   = LAST_ROW;
                        cnt_d   = '0;
                    end
                end
                CLR_SCAN: begin
                    // dst never rises above src's old position, so rows above
                    // src are still untouched when they get copied down.
                    if (src_full) begin
                        if (cnt_q != 3'd7) begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        rows_d[dst_q[YW-1:0]] = src_row;
                        dst_d = dst_q - ONE;
                    end
                    src_d = src_q - ONE;
                    if (src_q == '0) begin
                        state_d = dst_d[YW] ? CLR_DONE : CLR_FILL;
                    end
                end
                CLR_FILL: begin
                    rows_d[dst_q[YW-1:0]] = '0;
                    dst_d = dst_q - ONE;
                    if (dst_q == '0) begin
                        state_d = CLR_DONE;
                    end
                end
                CLR_DONE: begin
                    lines_d = cnt_q;
                    state_d = CLR_IDLE;
                end
                default: state_d = CLR_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ROWS; i++) begin
                rows_q[i] <= '0;
            end
            state_q <= CLR_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            vga_q   <= 1'b0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                rows_q[i] <= rows_d[i];
            end
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            vga_q   <= vga_d;
        end
    end

endmodule

// File: tb/tb_board_store.sv
// Directed bench for board_store: ports, line clears, clear_all and async reset.
module tb_board_store;
    import tetris_pkg::*;

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0;
    logic [XW-1:0] board_rx = '0;
    logic [YW-1:0] board_ry = '0;
    logic          board_rdata;
    logic          board_we = 1'b0;
    logic [XW-1:0] board_wx = '0;
    logic [YW-1:0] board_wy = '0;
    logic          board_wdata = 1'b0;
    logic [XW-1:0] vga_rx = '0;
    logic [YW-1:0] vga_ry = '0;
    logic          vga_rdata;
    logic          clear_start = 1'b0;
    logic          clear_all = 1'b0;
    logic          busy;
    logic          clear_done;
    logic [2:0]    lines_cleared;
    logic          top_occupied;

    int n_checks = 0;
    int n_err = 0;
    logic [COLS-1:0] exp_img [ROWS];

    board_store dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .board_rx      (board_rx),
        .board_ry      (board_ry),
        .board_rdata   (board_rdata),
        .board_we      (board_we),
        .board_wx      (board_wx),
        .board_wy      (board_wy),
        .board_wdata   (board_wdata),
        .vga_rx        (vga_rx),
        .vga_ry        (vga_ry),
        .vga_rdata     (vga_rdata),
        .clear_start   (clear_start),
        .clear_all     (clear_all),
        .busy          (busy),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .top_occupied  (top_occupied)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int x, input int y, input logic d);
        board_we    = 1'b1;
        board_wx    = XW'(x);
        board_wy    = YW'(y);
        board_wdata = d;
        tick;
        board_we    = 1'b0;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < COLS; x++) wr(x, y, 1'b1);
    endtask

    task automatic clr_all;
        clear_all = 1'b1;
        tick;
        clear_all = 1'b0;
        for (int y = 0; y < ROWS; y++) exp_img[y] = '0;
    endtask

    // Reads the whole board through the game port and compares with exp_img.
    task automatic snap_check(input string tag);
        logic [ROWS*COLS-1:0] o;
        logic [ROWS*COLS-1:0] e;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                board_rx = XW'(x);
                board_ry = YW'(y);
                #1;
                o[y*COLS+x] = board_rdata;
                e[y*COLS+x] = exp_img[y][x];
            end
        end
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: board observed %h expected %h", tag, o, e);
        end
        tick;
    endtask

    task automatic run_clear(input int n, input bit wr_busy, input string tag);
        int cyc;
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        while (!clear_done && cyc < 80) begin
            if (wr_busy && cyc == 3) begin
                board_we    = 1'b1;
                board_wx    = 4'd7;
                board_wy    = 5'd0;
                board_wdata = 1'b1;
            end
            tick;
            board_we = 1'b0;
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(ROWS + n + 1));
        tick;
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(clear_done), 32'd0);
        chk({tag, "_lines"}, 32'(lines_cleared), 32'(n));
    endtask

    initial begin
        logic acc_b;
        logic acc_v;
        logic done_seen;

        for (int y = 0; y < ROWS; y++) exp_img[y] = '0;

        // 1: reset state and empty board on both ports
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        chk("rst_lines", 32'(lines_cleared), 32'd0);
        chk("rst_vga", 32'(vga_rdata), 32'd0);
        chk("rst_top", 32'(top_occupied), 32'd0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        tick;
        acc_b = 1'b0;
        acc_v = 1'b0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                board_rx = XW'(x);
                board_ry = YW'(y);
                vga_rx   = XW'(x);
                vga_ry   = YW'(y);
                #1;
                acc_b |= board_rdata;
                tick;
                acc_v |= vga_rdata;
            end
        end
        chk("empty_game", 32'(acc_b), 32'd0);
        chk("empty_vga", 32'(acc_v), 32'd0);
        board_rx = 4'd10; board_ry = 5'd0; #1;
        chk("wall_x", 32'(board_rdata), 32'd1);
        board_rx = 4'd0; board_ry = 5'd20; #1;
        chk("wall_y", 32'(board_rdata), 32'd1);
        chk("empty_top", 32'(top_occupied), 32'd0);
        tick;

        // 2: single write on both read ports
        wr(3, 19, 1'b1);
        board_rx = 4'd3; board_ry = 5'd19; #1;
        chk("wr_game", 32'(board_rdata), 32'd1);
        board_rx = 4'd4; #1;
        chk("wr_neighbour", 32'(board_rdata), 32'd0);
        vga_rx = 4'd3; vga_ry = 5'd19;
        tick;
        chk("wr_vga", 32'(vga_rdata), 32'd1);
        vga_ry = 5'd20;
        tick;
        chk("vga_oob", 32'(vga_rdata), 32'd0);

        // 3: one full row at the bottom
        clr_all;
        snap_check("clear_all_wipe");
        fill_row(19);
        wr(0, 18, 1'b1);
        run_clear(1, 1'b0, "t3");
        exp_img[19] = 10'b00_0000_0001;
        snap_check("t3_board");

        // 4: four non-contiguous full rows
        clr_all;
        fill_row(19);
        fill_row(17);
        fill_row(16);
        fill_row(15);
        wr(5, 18, 1'b1);
        wr(2, 14, 1'b1);
        run_clear(4, 1'b0, "t4");
        exp_img[19] = 10'b00_0010_0000;
        exp_img[18] = 10'b00_0000_0100;
        snap_check("t4_board");

        // 5: no full rows, write while busy is dropped
        run_clear(0, 1'b1, "t5");
        snap_check("t5_board");
        wr(4, 0, 1'b1);
        chk("t5_top", 32'(top_occupied), 32'd1);

        // 6a: clear_all aborts a scan
        fill_row(19);
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        repeat (7) tick;
        chk("t6a_busy_mid", 32'(busy), 32'd1);
        clear_all = 1'b1;
        tick;
        clear_all = 1'b0;
        for (int y = 0; y < ROWS; y++) exp_img[y] = '0;
        chk("t6a_busy_abort", 32'(busy), 32'd0);
        done_seen = clear_done;
        repeat (30) begin
            tick;
            done_seen |= clear_done;
        end
        chk("t6a_no_done", 32'(done_seen), 32'd0);
        snap_check("t6a_board");

        // 6b: async reset during FILL
        fill_row(19);
        run_clear(1, 1'b0, "t6b_pre");
        fill_row(19);
        wr(0, 0, 1'b1);
        vga_rx = 4'd0; vga_ry = 5'd0;
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        repeat (20) tick;
        chk("t6b_busy_fill", 32'(busy), 32'd1);
        chk("t6b_top_fill", 32'(top_occupied), 32'd1);
        chk("t6b_vga_fill", 32'(vga_rdata), 32'd1);
        chk("t6b_lines_fill", 32'(lines_cleared), 32'd1);
        resetn = 1'b0;
        #2;
        chk("t6b_rst_busy", 32'(busy), 32'd0);
        chk("t6b_rst_done", 32'(clear_done), 32'd0);
        chk("t6b_rst_lines", 32'(lines_cleared), 32'd0);
        chk("t6b_rst_vga", 32'(vga_rdata), 32'd0);
        chk("t6b_rst_top", 32'(top_occupied), 32'd0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        tick;
        for (int y = 0; y < ROWS; y++) exp_img[y] = '0;
        snap_check("t6b_board");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
